// File: rtl/param_dataflow.sv
// param_dataflow: parameterised register-transfer datapath driven by micro-ops.
// One micro-op moves a source onto an AW-wide internal bus and into a destination,
// optionally through the ALU (destination AC) and with AR/PC post-increment.
// Micro-ops touching memory run through a small IDLE -> MEM -> DONE handshake
// with an ack timeout; everything else completes in the accepting cycle.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   uop_valid / uop_ready      micro-op handshake
//   uop_src, uop_dst, uop_idx  bus source, bus destination, register index
//   uop_alu                    ALU op used when the destination is AC
//   uop_arinc, uop_pcinc       post-increment AR / PC on completion
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack   memory port
//   ir_q, ac_q, r_sel_q, pc_q  architectural register views
//   z_q, c_q                   zero / carry flags
//   err                        sticky error (illegal micro-op or memory timeout)
module param_dataflow #(
    parameter int unsigned DW   = 8,
    parameter int unsigned AW   = 16,
    parameter int unsigned NREG = 4,
    parameter int unsigned TMO  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uop_valid,
    output logic                    uop_ready,
    input  logic [2:0]              uop_src,
    input  logic [2:0]              uop_dst,
    input  logic [$clog2(NREG)-1:0] uop_idx,
    input  logic [2:0]              uop_alu,
    input  logic                    uop_arinc,
    input  logic                    uop_pcinc,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    input  logic [DW-1:0]           mem_rdata,
    input  logic                    mem_ack,
    output logic [DW-1:0]           ir_q,
    output logic [DW-1:0]           ac_q,
    output logic [DW-1:0]           r_sel_q,
    output logic [AW-1:0]           pc_q,
    output logic                    z_q,
    output logic                    c_q,
    output logic                    err
);

    localparam int unsigned IW = $clog2(NREG);
    localparam int unsigned TW = $clog2(TMO + 1);

    localparam logic [2:0] SRC_PC  = 3'd0, SRC_DRL = 3'd1, SRC_DRH = 3'd2, SRC_R  = 3'd3,
                           SRC_AC  = 3'd4, SRC_MEM = 3'd5, SRC_TR  = 3'd6;
    localparam logic [2:0] DST_AR  = 3'd0, DST_PC  = 3'd1, DST_DR  = 3'd2, DST_R  = 3'd3,
                           DST_AC  = 3'd4, DST_MEM = 3'd5, DST_IR  = 3'd6, DST_TR = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   ar, pc, bus;
    logic [DW-1:0]   dr, ir, tr, ac, wdata, b_op;
    logic [DW-1:0]   r [NREG];
    logic            z, c, err_r;
    logic [TW-1:0]   tmo_cnt;
    logic [DW:0]     alu_res;

    // Micro-op fields held for the duration of a memory access
    logic [2:0]      l_src, l_dst, l_alu;
    logic [IW-1:0]   l_idx;
    logic            l_arinc, l_pcinc, l_we;

    logic [2:0]      sel_src, sel_dst, sel_alu;
    logic [IW-1:0]   sel_idx;
    logic            sel_arinc, sel_pcinc;
    logic            commit, start_mem, set_err, tmo_inc;
    logic            is_mem, illegal;

    // Live fields in IDLE, latched fields while the memory access completes
    always_comb begin
        if (state == S_MEM) begin
            sel_src = l_src;   sel_dst = l_dst;   sel_alu = l_alu;
            sel_idx = l_idx;   sel_arinc = l_arinc; sel_pcinc = l_pcinc;
        end else begin
            sel_src = uop_src; sel_dst = uop_dst; sel_alu = uop_alu;
            sel_idx = uop_idx; sel_arinc = uop_arinc; sel_pcinc = uop_pcinc;
        end
    end

    // Internal bus: DRH places DR in the second byte lane, unused sources read 0
    always_comb begin
        bus = '0;
        case (sel_src)
            SRC_PC:  bus = pc;
            SRC_DRL: bus = AW'(dr);
            SRC_DRH: bus = AW'(dr) << DW;
            SRC_R:   bus = AW'(r[sel_idx]);
            SRC_AC:  bus = AW'(ac);
            SRC_MEM: bus = AW'(mem_rdata);
            SRC_TR:  bus = AW'(tr);
            default: bus = '0;
        endcase
    end

    // ALU: bit DW is carry-out for add and borrow for sub, 0 otherwise
    always_comb begin
        b_op    = bus[DW-1:0];
        alu_res = '0;
        case (sel_alu)
            3'd0:    alu_res = {1'b0, b_op};
            3'd1:    alu_res = {1'b0, ac} + {1'b0, b_op};
            3'd2:    alu_res = {1'b0, ac} - {1'b0, b_op};
            3'd3:    alu_res = {1'b0, ac & b_op};
            3'd4:    alu_res = {1'b0, ac | b_op};
            3'd5:    alu_res = {1'b0, ac ^ b_op};
            3'd6:    alu_res = {1'b0, ~ac};
            default: alu_res = '0;
        endcase
    end

    assign is_mem  = (uop_src == SRC_MEM) || (uop_dst == DST_MEM);
    assign illegal = (uop_src == SRC_MEM) && (uop_dst == DST_MEM);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state and control
    always_comb begin
        state_nxt = state;
        uop_ready = 1'b0;
        mem_req   = 1'b0;
        commit    = 1'b0;
        start_mem = 1'b0;
        set_err   = 1'b0;
        tmo_inc   = 1'b0;
        case (state)
            S_IDLE: begin
                uop_ready = !rst;
                if (uop_valid) begin
                    if (illegal) begin
                        set_err = 1'b1;
                    end else if (is_mem) begin
                        start_mem = 1'b1;
                        state_nxt = S_MEM;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    commit    = 1'b1;
                    state_nxt = S_DONE;
                end else if (tmo_cnt == TW'(TMO - 1)) begin
                    set_err   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar <= '0; pc <= '0; dr <= '0; ir <= '0; tr <= '0; ac <= '0;
            z <= 1'b0; c <= 1'b0; err_r <= 1'b0; tmo_cnt <= '0; wdata <= '0;
            l_src <= '0; l_dst <= '0; l_alu <= '0; l_idx <= '0;
            l_arinc <= 1'b0; l_pcinc <= 1'b0; l_we <= 1'b0;
            for (int i = 0; i < NREG; i++) r[i] <= '0;
        end else begin
            if (set_err) err_r <= 1'b1;
            if (start_mem) begin
                l_src <= uop_src; l_dst <= uop_dst; l_alu <= uop_alu; l_idx <= uop_idx;
                l_arinc <= uop_arinc; l_pcinc <= uop_pcinc;
                l_we    <= (uop_dst == DST_MEM);
                wdata   <= bus[DW-1:0];
                tmo_cnt <= '0;
            end else if (tmo_inc) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (commit) begin
                case (sel_dst)
                    DST_AR:  ar <= bus;
                    DST_PC:  pc <= bus;
                    DST_DR:  dr <= bus[DW-1:0];
                    DST_R:   r[sel_idx] <= bus[DW-1:0];
                    DST_AC: begin
                        ac <= alu_res[DW-1:0];
                        z  <= (alu_res[DW-1:0] == '0);
                        c  <= alu_res[DW];
                    end
                    DST_IR:  ir <= bus[DW-1:0];
                    DST_TR:  tr <= bus[DW-1:0];
                    default: ;
                endcase
                // A load into the same register takes priority over its increment
                if (sel_arinc && sel_dst != DST_AR) ar <= ar + AW'(1);
                if (sel_pcinc && sel_dst != DST_PC) pc <= pc + AW'(1);
            end
        end
    end

    assign mem_we    = mem_req && l_we;
    assign mem_addr  = ar;
    assign mem_wdata = wdata;
    assign ir_q      = ir;
    assign ac_q      = ac;
    assign r_sel_q   = r[uop_idx];
    assign pc_q      = pc;
    assign z_q       = z;
    assign c_q       = c;
    assign err       = err_r;

endmodule
